// File: rtl/instr_mem_block.sv
// Instruction store for the sequencer memory-block interface: the host loads (header, payload)
// word pairs while the sequencer is rewound, and the sequencer pops one instruction per mblock_en rise.
module instr_mem_block #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [15:0]       wr_data,
    input  logic              prog_clr,
    input  logic              mblock_en,
    input  logic              mblock_clr,
    output logic              mblock_valid,
    output logic [3:0]        dev_no,
    output logic [15:0]       data_bus,
    output logic [ADDR_W:0]   instr_count,
    output logic              full,
    output logic              half_pending,
    output logic              wr_err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [19:0]       mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [3:0]        hdr;
    logic              en_d;

    logic              word_ok;
    logic              hdr_accept;
    logic              commit;
    logic              drop;
    logic              pop;
    logic              pop_hit;

    // Handshake: the host offers one word per wr_en cycle with no back-pressure; a word it is
    // not allowed to write is dropped and flagged in wr_err. The sequencer pops on each
    // mblock_en rise and mblock_valid tells it whether that pop will return a new instruction.
    assign word_ok    = wr_en & mblock_clr & ~prog_clr & (half_pending | ~full);
    assign hdr_accept = word_ok & ~half_pending;
    assign commit     = word_ok & half_pending;
    assign drop       = wr_en & ~prog_clr & (~mblock_clr | (full & ~half_pending));

    assign pop     = mblock_en & ~en_d & ~mblock_clr & ~prog_clr;
    assign pop_hit = pop & (rd_ptr != wr_ptr);

    assign instr_count  = wr_ptr;
    assign full         = (wr_ptr == DEPTH_CNT);
    assign mblock_valid = ~mblock_clr & (rd_ptr != wr_ptr);

    // RAM array is never reset so it can map onto a block memory.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {hdr, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dev_no   <= '0;
            data_bus <= '0;
        end else if (pop_hit) begin
            {dev_no, data_bus} <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_d <= 1'b0;
        end else begin
            en_d <= mblock_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr <= '0;
        end else if (hdr_accept) begin
            hdr <= wr_data[3:0];
        end
    end

    // prog_clr outranks every write, drop and pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            half_pending <= 1'b0;
            wr_err       <= 1'b0;
        end else if (prog_clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            half_pending <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mblock_clr) begin
                rd_ptr <= '0;
            end else if (pop_hit) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (hdr_accept) begin
                half_pending <= 1'b1;
            end else if (commit) begin
                half_pending <= 1'b0;
            end
            if (drop) begin
                wr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_block.sv
// Bench for instr_mem_block: directed program load/pop/rewind/fill/erase steps, then random
// traffic checked against a program-queue reference model.
module tb_instr_mem_block;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [15:0]       wr_data;
    logic              prog_clr;
    logic              mblock_en;
    logic              mblock_clr;
    logic              mblock_valid;
    logic [3:0]        dev_no;
    logic [15:0]       data_bus;
    logic [ADDR_W:0]   instr_count;
    logic              full;
    logic              half_pending;
    logic              wr_err;

    int n_assert;
    int n_fail;

    // reference model: the stored program as a list, a read cursor and the host-side flags
    logic [19:0] m_prog[$];
    int          m_cursor;
    bit          m_pend;
    logic [3:0]  m_hdr;
    bit          m_err;
    bit          m_en_d;
    logic [3:0]  m_dev;
    logic [15:0] m_data;

    instr_mem_block #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .prog_clr     (prog_clr),
        .mblock_en    (mblock_en),
        .mblock_clr   (mblock_clr),
        .mblock_valid (mblock_valid),
        .dev_no       (dev_no),
        .data_bus     (data_bus),
        .instr_count  (instr_count),
        .full         (full),
        .half_pending (half_pending),
        .wr_err       (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prog.delete();
        m_cursor = 0;
        m_pend   = 0;
        m_hdr    = '0;
        m_err    = 0;
        m_en_d   = 0;
        m_dev    = '0;
        m_data   = '0;
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        if (prog_clr) begin
            m_prog.delete();
            m_cursor = 0;
            m_pend   = 0;
            m_err    = 0;
        end else begin
            if (wr_en) begin
                if (!mblock_clr) m_err = 1;
                else if (!m_pend) begin
                    if (m_prog.size() == DEPTH) m_err = 1;
                    else begin
                        m_hdr  = wr_data[3:0];
                        m_pend = 1;
                    end
                end else begin
                    m_prog.push_back({m_hdr, wr_data});
                    m_pend = 0;
                end
            end
            if (mblock_clr) m_cursor = 0;
            else if (mblock_en && !m_en_d && m_cursor < m_prog.size()) begin
                {m_dev, m_data} = m_prog[m_cursor];
                m_cursor++;
            end
        end
        m_en_d = mblock_en;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr_count"},  32'(instr_count),  32'(m_prog.size()));
        chk({tag, ".full"},         32'(full),         32'(m_prog.size() == DEPTH));
        chk({tag, ".half_pending"}, 32'(half_pending), 32'(m_pend));
        chk({tag, ".wr_err"},       32'(wr_err),       32'(m_err));
        chk({tag, ".mblock_valid"}, 32'(mblock_valid), 32'(!mblock_clr && m_cursor < m_prog.size()));
        chk({tag, ".dev_no"},       32'(dev_no),       32'(m_dev));
        chk({tag, ".data_bus"},     32'(data_bus),     32'(m_data));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic host_word(input logic [15:0] w, input string tag);
        wr_en   = 1'b1;
        wr_data = w;
        tick(tag);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_pop(input string tag);
        mblock_en = 1'b1;
        tick(tag);
        mblock_en = 1'b0;
        tick(tag);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        prog_clr   = 1'b0;
        mblock_en  = 1'b0;
        mblock_clr = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("post_reset");

        // load three instructions while rewound
        mblock_clr = 1'b1;
        host_word(16'h0001, "ld_h0");
        host_word(16'h1234, "ld_p0");
        host_word(16'hFFF3, "ld_h1");
        host_word(16'h00AA, "ld_p1");
        host_word(16'h0000, "ld_h2");
        host_word(16'h0000, "ld_p2");
        mblock_clr = 1'b0;
        #1;
        chk("loaded.count", 32'(instr_count), 32'd3);
        chk("loaded.valid", 32'(mblock_valid), 32'd1);

        // a level held for two cycles gives one pop
        mblock_en = 1'b1;
        tick("hold_1");
        chk("pop1.dev_no", 32'(dev_no), 32'h1);
        chk("pop1.data",   32'(data_bus), 32'h1234);
        tick("hold_2");
        mblock_en = 1'b0;
        tick("hold_rel");
        pulse_pop("pop2");
        chk("pop2.dev_no", 32'(dev_no), 32'h3);
        chk("pop2.data",   32'(data_bus), 32'h00AA);
        pulse_pop("pop3");
        chk("pop3.valid", 32'(mblock_valid), 32'd0);
        pulse_pop("pop_empty");
        chk("empty.data", 32'(data_bus), 32'h0000);

        // one-cycle rewind then replay
        mblock_clr = 1'b1;
        tick("rewind");
        mblock_clr = 1'b0;
        #1;
        chk("rewind.valid", 32'(mblock_valid), 32'd1);
        pulse_pop("replay");
        chk("replay.dev_no", 32'(dev_no), 32'h1);
        chk("replay.data",   32'(data_bus), 32'h1234);
        chk("replay.count",  32'(instr_count), 32'd3);

        // fill to capacity from an empty program
        prog_clr = 1'b1;
        tick("erase");
        prog_clr   = 1'b0;
        mblock_clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_word(16'(i + 5), "fill_h");
            host_word(16'(16'hA000 + i), "fill_p");
        end
        chk("fill.count", 32'(instr_count), 32'(DEPTH));
        chk("fill.full",  32'(full), 32'd1);
        chk("fill.err",   32'(wr_err), 32'd1);

        // write while not rewound is dropped
        prog_clr = 1'b1;
        tick("erase2");
        prog_clr   = 1'b0;
        mblock_clr = 1'b0;
        host_word(16'h0007, "wr_live");
        chk("wr_live.err", 32'(wr_err), 32'd1);

        // header only, then erase colliding with a write
        prog_clr   = 1'b1;
        tick("erase3");
        prog_clr   = 1'b0;
        mblock_clr = 1'b1;
        host_word(16'h0009, "hdr_only");
        chk("hdr_only.pend", 32'(half_pending), 32'd1);
        prog_clr = 1'b1;
        host_word(16'h5555, "clr_vs_wr");
        prog_clr = 1'b0;
        chk("clr_vs_wr.pend", 32'(half_pending), 32'd0);
        chk("clr_vs_wr.err",  32'(wr_err), 32'd0);

        // random traffic
        mblock_clr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            mblock_clr = ($urandom_range(0, 9) < 4);
            wr_en      = $urandom_range(0, 1);
            wr_data    = 16'($urandom);
            prog_clr   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) mblock_en = ~mblock_en;
            tick("rand");
        end
        wr_en    = 1'b0;
        prog_clr = 1'b0;

        // reload one instruction, start a pop and reset before the edge
        mblock_clr = 1'b1;
        host_word(16'h000C, "rl_h");
        host_word(16'hBEEF, "rl_p");
        mblock_clr = 1'b0;
        mblock_en  = 1'b0;
        tick("rl_idle");
        pulse_pop("rl_pop");
        mblock_en = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        mblock_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
